// File: rtl/z2_dma_master.sv
// Zorro II / 68000 bus initiator for card-side DMA.
// Arbitrates with BR_n/BG_n/BGACK_n, then runs single word or byte cycles
// terminated by DTACK_n, BERR_n or a local timeout. Requests arrive on a
// valid/ready port and each one is answered by a one-cycle rsp_valid pulse.
// Register updates are made on the clock edge that leaves a state, so the
// outputs named for a state become visible on the following cycle.

module z2_dma_master #(
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned ADDR_SETUP    = 2,  // must be >= 1
    parameter int unsigned WR_DATA_SETUP = 1   // must be >= 1
) (
    input  logic        MEMCLK,
    input  logic        RESET_n,

    // Local request / response port
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [22:0] req_addr,
    input  logic        req_uds,
    input  logic        req_lds,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_rdata,

    // Arbitration
    output logic        BR_n,
    input  logic        BG_n,
    input  logic        BGACK_n_in,
    output logic        BGACK_n,

    // Bus cycle
    input  logic        AS_n_in,
    input  logic        DTACK_n,
    input  logic        BERR_n,
    output logic        bus_oe,
    output logic [22:0] ADDR_o,
    output logic        AS_n_o,
    output logic        UDS_n_o,
    output logic        LDS_n_o,
    output logic        RW_o,
    output logic        data_oe,
    output logic [15:0] DOUT,
    input  logic [15:0] DIN
);

    localparam logic [15:0] ASETUP_LAST = 16'(ADDR_SETUP - 1);
    localparam logic [15:0] WSETUP_LAST = 16'(WR_DATA_SETUP - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        StIdle,
        StArb,
        StOwn,
        StSetup,
        StWrStb,
        StWaitAck,
        StAckData,
        StNullRsp,
        StEnd,
        StRecover
    } state_e;

    state_e      state_q;
    logic [15:0] cnt_q;
    logic        uds_q;
    logic        lds_q;

    // Bit order: {BG_n, BGACK_n_in, AS_n_in, DTACK_n, BERR_n}
    logic [4:0]  sync1_q;
    logic [4:0]  sync2_q;

    logic bg_s;
    logic bgack_s;
    logic as_s;
    logic dtack_s;
    logic berr_s;

    assign bg_s    = sync2_q[4];
    assign bgack_s = sync2_q[3];
    assign as_s    = sync2_q[2];
    assign dtack_s = sync2_q[1];
    assign berr_s  = sync2_q[0];

    logic grant;
    logic finish;
    logic finish_err;

    // Two-flop synchronisers for the asynchronous bus control inputs (idle high)
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {BG_n, BGACK_n_in, AS_n_in, DTACK_n, BERR_n};
            sync2_q <= sync1_q;
        end
    end

    // Bus is ours once granted and the previous master has fully let go
    assign grant = !bg_s && as_s && bgack_s && dtack_s;

    // Decide when the current transfer ends this cycle and with what status.
    // BERR beats DTACK, DTACK beats the timeout; a read DTACK first goes
    // through StAckData so DIN is sampled one cycle later.
    always_comb begin
        finish     = 1'b0;
        finish_err = 1'b0;
        case (state_q)
            StWaitAck: begin
                if (!berr_s) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (!dtack_s) begin
                    finish     = !RW_o;
                end else if (cnt_q == TMO_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            StAckData: begin
                finish     = 1'b1;
            end
            StNullRsp: begin
                finish     = 1'b1;
                finish_err = 1'b1;
            end
            default: begin
                finish     = 1'b0;
                finish_err = 1'b0;
            end
        endcase
    end

    // Main sequencer with registered bus and response outputs
    always_ff @(posedge MEMCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            uds_q     <= 1'b0;
            lds_q     <= 1'b0;
            BR_n      <= 1'b1;
            BGACK_n   <= 1'b1;
            bus_oe    <= 1'b0;
            data_oe   <= 1'b0;
            AS_n_o    <= 1'b1;
            UDS_n_o   <= 1'b1;
            LDS_n_o   <= 1'b1;
            RW_o      <= 1'b1;
            ADDR_o    <= '0;
            DOUT      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        BR_n    <= 1'b0;
                        state_q <= StArb;
                    end
                end

                StArb: begin
                    if (grant) begin
                        BGACK_n <= 1'b0;
                        state_q <= StOwn;
                    end
                end

                StOwn: begin
                    BR_n      <= 1'b1;
                    req_ready <= 1'b1;
                    cnt_q     <= '0;
                    if (!req_uds && !req_lds) begin
                        // Nothing to strobe: answer with an error, no bus cycle
                        state_q <= StNullRsp;
                    end else begin
                        bus_oe  <= 1'b1;
                        ADDR_o  <= req_addr;
                        RW_o    <= req_rw;
                        uds_q   <= req_uds;
                        lds_q   <= req_lds;
                        if (!req_rw) begin
                            DOUT    <= req_wdata;
                            data_oe <= 1'b1;
                        end
                        state_q <= StSetup;
                    end
                end

                StSetup: begin
                    if (cnt_q == ASETUP_LAST) begin
                        AS_n_o <= 1'b0;
                        cnt_q  <= '0;
                        if (RW_o) begin
                            UDS_n_o <= !uds_q;
                            LDS_n_o <= !lds_q;
                            state_q <= StWaitAck;
                        end else begin
                            state_q <= StWrStb;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StWrStb: begin
                    if (cnt_q == WSETUP_LAST) begin
                        UDS_n_o <= !uds_q;
                        LDS_n_o <= !lds_q;
                        cnt_q   <= '0;
                        state_q <= StWaitAck;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                StWaitAck: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (berr_s && !dtack_s && RW_o) begin
                        state_q <= StAckData;
                    end
                end

                StAckData: begin
                    rsp_rdata <= DIN;
                end

                StNullRsp: begin
                    // Completion handled by the finish path below
                end

                StEnd: begin
                    state_q <= StRecover;
                end

                StRecover: begin
                    if (dtack_s && berr_s) begin
                        if (req_valid) begin
                            // Keep BGACK_n low and run the next transfer
                            state_q <= StOwn;
                        end else begin
                            bus_oe  <= 1'b0;
                            BGACK_n <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase

            // Common completion: drop strobes and data, report the result
            if (finish) begin
                AS_n_o    <= 1'b1;
                UDS_n_o   <= 1'b1;
                LDS_n_o   <= 1'b1;
                data_oe   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= finish_err;
                state_q   <= StEnd;
            end
        end
    end

endmodule

// File: tb/tb_z2_dma_master.sv
// Directed bench for z2_dma_master: a simple CPU arbiter and bus target
// respond to the DMA master; expected responses are queued at issue time
// and compared as each rsp_valid pulse is observed.

module tb_z2_dma_master;

    localparam int unsigned TIMEOUT    = 255;
    localparam int unsigned ADDR_SETUP = 2;

    logic        MEMCLK;
    logic        RESET_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [22:0] req_addr;
    logic        req_uds;
    logic        req_lds;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        BR_n;
    logic        BG_n;
    logic        BGACK_n_in;
    logic        BGACK_n;
    logic        AS_n_in;
    logic        DTACK_n;
    logic        BERR_n;
    logic        bus_oe;
    logic [22:0] ADDR_o;
    logic        AS_n_o;
    logic        UDS_n_o;
    logic        LDS_n_o;
    logic        RW_o;
    logic        data_oe;
    logic [15:0] DOUT;
    logic [15:0] DIN;

    z2_dma_master #(
        .TIMEOUT       (TIMEOUT),
        .ADDR_SETUP    (ADDR_SETUP),
        .WR_DATA_SETUP (1)
    ) dut (
        .MEMCLK     (MEMCLK),
        .RESET_n    (RESET_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_uds    (req_uds),
        .req_lds    (req_lds),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .BR_n       (BR_n),
        .BG_n       (BG_n),
        .BGACK_n_in (BGACK_n_in),
        .BGACK_n    (BGACK_n),
        .AS_n_in    (AS_n_in),
        .DTACK_n    (DTACK_n),
        .BERR_n     (BERR_n),
        .bus_oe     (bus_oe),
        .ADDR_o     (ADDR_o),
        .AS_n_o     (AS_n_o),
        .UDS_n_o    (UDS_n_o),
        .LDS_n_o    (LDS_n_o),
        .RW_o       (RW_o),
        .data_oe    (data_oe),
        .DOUT       (DOUT),
        .DIN        (DIN)
    );

    // The bus as sensed: only the DMA master drives BGACK_n and AS_n here
    assign BGACK_n_in = BGACK_n;
    assign AS_n_in    = bus_oe ? AS_n_o : 1'b1;

    initial MEMCLK = 1'b0;
    always #5 MEMCLK = ~MEMCLK;

    int cyc = 0;
    always @(posedge MEMCLK) cyc <= cyc + 1;

    typedef struct packed {
        logic        err;
        logic        chk_data;
        logic [15:0] data;
    } rsp_t;

    rsp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;
    int seen_rsp = 0;

    // Target behaviour: 0 = DTACK, 1 = BERR+DTACK together, 2 = never answer
    int          tgt_mode = 0;
    int          tgt_dly  = 6;
    logic [15:0] tgt_data = 16'h0000;

    // Observations taken at the falling edge (single writer for each)
    int          t_oe = 0, t_as = 0, t_lds = 0, t_rsp = 0;
    int          as_falls = 0, uds_falls = 0, br_falls = 0, bgack_rises = 0;
    int          bgack_falls = 0, overlap = 0, rsp_cnt = 0;
    logic [22:0] addr_at_as = '0;
    logic        rw_at_as = 1'b0;
    logic [15:0] dout_at_lds = '0;
    logic        doe_at_lds = 1'b0, doe_at_rsp = 1'b0;
    logic        last_err = 1'b0;
    logic [15:0] last_data = '0;
    logic        oe_p = 1'b0, as_p = 1'b1, lds_p = 1'b1, uds_p = 1'b1;
    logic        br_p = 1'b1, bgack_p = 1'b1;

    always @(negedge MEMCLK) begin
        if (bus_oe && !oe_p) t_oe = cyc;
        if (!AS_n_o && as_p) begin
            t_as       = cyc;
            as_falls   = as_falls + 1;
            addr_at_as = ADDR_o;
            rw_at_as   = RW_o;
        end
        if (!LDS_n_o && lds_p) begin
            t_lds       = cyc;
            dout_at_lds = DOUT;
            doe_at_lds  = data_oe;
        end
        if (!UDS_n_o && uds_p) uds_falls = uds_falls + 1;
        if (!BR_n && br_p) br_falls = br_falls + 1;
        if (!BGACK_n && bgack_p) bgack_falls = bgack_falls + 1;
        if (BGACK_n && !bgack_p) bgack_rises = bgack_rises + 1;
        if (rsp_valid) begin
            t_rsp      = cyc;
            doe_at_rsp = data_oe;
            last_err   = rsp_err;
            last_data  = rsp_rdata;
            rsp_cnt    = rsp_cnt + 1;
        end
        if (rsp_valid && req_ready) overlap = overlap + 1;
        oe_p    = bus_oe;
        as_p    = AS_n_o;
        lds_p   = LDS_n_o;
        uds_p   = UDS_n_o;
        br_p    = BR_n;
        bgack_p = BGACK_n;
    end

    // CPU side: grant follows the request
    initial begin
        BG_n = 1'b1;
        forever begin
            @(posedge MEMCLK);
            #2;
            BG_n = BR_n;
        end
    end

    // Bus target: acknowledges a programmable number of cycles after the strobes
    initial begin
        int scnt;
        scnt    = 0;
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
        DIN     = 16'h0000;
        forever begin
            @(posedge MEMCLK);
            #2;
            if (AS_n_o) begin
                DTACK_n = 1'b1;
                BERR_n  = 1'b1;
                scnt    = 0;
            end else if (!UDS_n_o || !LDS_n_o) begin
                scnt = scnt + 1;
                if (scnt == tgt_dly) begin
                    if (tgt_mode == 0) begin
                        DIN     = tgt_data;
                        DTACK_n = 1'b0;
                    end else if (tgt_mode == 1) begin
                        DIN     = 16'hFFFF;
                        DTACK_n = 1'b0;
                        BERR_n  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge MEMCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_req(input logic rw, input logic [22:0] a, input logic u,
                             input logic l, input logic [15:0] wd);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = a;
        req_uds   = u;
        req_lds   = l;
        req_wdata = wd;
    endtask

    task automatic wait_ready(input string tag, input bit drop);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_ready"}, 32'(got), 32'd1);
        if (drop) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int limit);
        bit   got;
        rsp_t e;
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rsp_cnt != seen_rsp) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_rsp_seen"}, 32'(got), 32'd1);
        if (got && exp_q.size() > 0) begin
            seen_rsp = seen_rsp + 1;
            e = exp_q.pop_front();
            chk({tag, "_err"}, 32'(last_err), 32'(e.err));
            if (e.chk_data) chk({tag, "_rdata"}, 32'(last_data), 32'(e.data));
        end
    endtask

    task automatic wait_release(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (bus_oe == 1'b0 && BGACK_n == 1'b1) break;
            step();
        end
        chk({tag, "_released"}, {30'd0, bus_oe, BGACK_n}, 32'b01);
    endtask

    initial begin
        int base;
        req_valid = 1'b0;
        req_rw    = 1'b1;
        req_addr  = '0;
        req_uds   = 1'b0;
        req_lds   = 1'b0;
        req_wdata = '0;
        RESET_n   = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_ctrl", {24'd0, BR_n, BGACK_n, bus_oe, data_oe, AS_n_o, UDS_n_o, LDS_n_o, RW_o},
            32'b1100_1111);
        chk("rst_addr", 32'(ADDR_o), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_rsp", {13'd0, req_ready, rsp_valid, rsp_err, rsp_rdata}, 32'd0);

        RESET_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle", {26'd0, BR_n, BGACK_n, bus_oe, AS_n_o, UDS_n_o, LDS_n_o}, 32'b110111);
        end

        // Word read
        tgt_mode = 0;
        tgt_dly  = 6;
        tgt_data = 16'hA5C3;
        base     = br_falls;
        drive_req(1'b1, 23'h200000, 1'b1, 1'b1, 16'h0000);
        exp_q.push_back('{err: 1'b0, chk_data: 1'b1, data: 16'hA5C3});
        wait_ready("rd", 1'b1);
        chk("rd_br_fell", 32'(br_falls - base), 32'd1);
        chk("rd_bgack", 32'(BGACK_n), 32'd0);
        wait_rsp("rd", 100);
        chk("rd_as_setup", 32'(t_as - t_oe), 32'(ADDR_SETUP));
        chk("rd_addr", 32'(addr_at_as), 32'h200000);
        chk("rd_rw", 32'(rw_at_as), 32'd1);
        wait_release("rd");

        // Byte write, lower lane only
        base = uds_falls;
        drive_req(1'b0, 23'h3FFFFF, 1'b0, 1'b1, 16'h0042);
        exp_q.push_back('{err: 1'b0, chk_data: 1'b0, data: 16'h0000});
        wait_ready("wr", 1'b1);
        wait_rsp("wr", 100);
        chk("wr_lds_delay", 32'(t_lds - t_as), 32'd1);
        chk("wr_uds_high", 32'(uds_falls - base), 32'd0);
        chk("wr_dout", 32'(dout_at_lds), 32'h0042);
        chk("wr_data_oe", 32'(doe_at_lds), 32'd1);
        chk("wr_doe_end", 32'(doe_at_rsp), 32'd0);
        chk("wr_addr", 32'(addr_at_as), 32'h3FFFFF);
        chk("wr_rw", 32'(rw_at_as), 32'd0);
        wait_release("wr");

        // BERR together with DTACK: error wins, read data held
        tgt_mode = 1;
        tgt_dly  = 3;
        drive_req(1'b1, 23'h000010, 1'b1, 1'b1, 16'h0000);
        exp_q.push_back('{err: 1'b1, chk_data: 1'b1, data: 16'hA5C3});
        wait_ready("berr", 1'b1);
        wait_rsp("berr", 100);
        wait_release("berr");

        // Timeout: target never answers
        tgt_mode = 2;
        drive_req(1'b1, 23'h000020, 1'b1, 1'b0, 16'h0000);
        exp_q.push_back('{err: 1'b1, chk_data: 1'b1, data: 16'hA5C3});
        wait_ready("tmo", 1'b1);
        wait_rsp("tmo", 400);
        chk("tmo_latency", 32'(t_rsp - t_as), 32'(TIMEOUT));
        wait_release("tmo");

        // No byte lanes selected: error response without a bus cycle
        base = as_falls;
        drive_req(1'b1, 23'h000030, 1'b0, 1'b0, 16'h0000);
        exp_q.push_back('{err: 1'b1, chk_data: 1'b0, data: 16'h0000});
        wait_ready("null", 1'b1);
        wait_rsp("null", 50);
        chk("null_no_as", 32'(as_falls - base), 32'd0);
        wait_release("null");

        // Back-to-back: second request queued while the first runs
        tgt_mode = 0;
        tgt_dly  = 2;
        tgt_data = 16'h1234;
        base     = bgack_rises;
        drive_req(1'b1, 23'h000100, 1'b1, 1'b1, 16'h0000);
        exp_q.push_back('{err: 1'b0, chk_data: 1'b1, data: 16'h1234});
        wait_ready("b2b_a", 1'b0);
        drive_req(1'b1, 23'h000102, 1'b1, 1'b1, 16'h0000);
        wait_rsp("b2b_a", 100);
        tgt_mode = 2;
        wait_ready("b2b_b", 1'b1);
        chk("b2b_bgack_held", 32'(bgack_rises - base), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (!AS_n_o) break;
            step();
        end
        chk("b2b_b_as_low", 32'(AS_n_o), 32'd0);
        chk("b2b_b_addr", 32'(ADDR_o), 32'h000102);
        step();
        step();
        step();

        // Reset in the middle of WAIT_ACK
        #2;
        RESET_n = 1'b0;
        #1;
        chk("rst_mid_bus", {29'd0, bus_oe, AS_n_o, BGACK_n}, 32'b011);
        chk("rst_mid_strb", {30'd0, UDS_n_o, LDS_n_o}, 32'b11);
        for (int i = 0; i < 5; i++) step();
        chk("rst_mid_no_rsp", 32'(rsp_cnt - seen_rsp), 32'd0);
        RESET_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("post_rst_no_rsp", 32'(rsp_cnt - seen_rsp), 32'd0);
        chk("post_rst_idle", {28'd0, BR_n, BGACK_n, bus_oe, AS_n_o}, 32'b1101);
        chk("no_ready_rsp_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
